// File: rtl/cpu_clk_ctrl.sv
// Clock-enable sequencer for the single-cycle CPU: free-run via a prescaler,
// debounced single-step, and halt on CPU request, all as one-cycle cpu_ce pulses.
module cpu_clk_ctrl #(
    parameter int unsigned          WIDTH     = 28,
    parameter logic [WIDTH-1:0]     DIVIDE_BY = 28'd50000000,
    parameter int unsigned          DB_WIDTH  = 20,
    parameter logic [DB_WIDTH-1:0]  DEBOUNCE  = 20'd500000
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic        halt_req,
    input  logic        clr_halt,
    output logic        cpu_ce,
    output logic [1:0]  state,
    output logic [15:0] cycle_cnt,
    output logic        tick_led
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_STEP   = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    localparam logic [WIDTH-1:0]    PRESC_LAST = DIVIDE_BY - {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DB_WIDTH-1:0] DB_LAST    = DEBOUNCE - {{(DB_WIDTH-1){1'b0}}, 1'b1};

    logic                run_meta_r, run_sync_r;
    logic                step_meta_r, step_sync_r;
    logic                halt_meta_r, halt_sync_r;
    logic                clr_meta_r, clr_sync_r;

    logic [DB_WIDTH-1:0] db_cnt_r, db_cnt_next_s;
    logic                db_level_r, db_level_next_s, db_level_d_r;
    logic                step_evt_s;

    logic [WIDTH-1:0]    presc_r, presc_next_s;
    logic                tick_s;

    logic [1:0]          state_r, state_next_s;
    logic                cpu_ce_r, cpu_ce_next_s;
    logic [15:0]         cycle_cnt_r;
    logic                tick_led_r;

    // Two-flop synchronizers for the asynchronous board inputs
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            run_meta_r  <= 1'b0;
            run_sync_r  <= 1'b0;
            step_meta_r <= 1'b0;
            step_sync_r <= 1'b0;
            halt_meta_r <= 1'b0;
            halt_sync_r <= 1'b0;
            clr_meta_r  <= 1'b0;
            clr_sync_r  <= 1'b0;
        end else begin
            run_meta_r  <= run_sw;
            run_sync_r  <= run_meta_r;
            step_meta_r <= step_btn;
            step_sync_r <= step_meta_r;
            halt_meta_r <= halt_req;
            halt_sync_r <= halt_meta_r;
            clr_meta_r  <= clr_halt;
            clr_sync_r  <= clr_meta_r;
        end
    end

    // Debounce: the level flips only after DEBOUNCE consecutive differing samples
    always_comb begin
        db_cnt_next_s   = {DB_WIDTH{1'b0}};
        db_level_next_s = db_level_r;
        if (step_sync_r != db_level_r) begin
            if (db_cnt_r == DB_LAST) begin
                db_cnt_next_s   = {DB_WIDTH{1'b0}};
                db_level_next_s = ~db_level_r;
            end else begin
                db_cnt_next_s   = db_cnt_r + {{(DB_WIDTH-1){1'b0}}, 1'b1};
                db_level_next_s = db_level_r;
            end
        end else begin
            db_cnt_next_s   = {DB_WIDTH{1'b0}};
            db_level_next_s = db_level_r;
        end
    end

    // Debounce state registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_r     <= {DB_WIDTH{1'b0}};
            db_level_r   <= 1'b0;
            db_level_d_r <= 1'b0;
        end else begin
            db_cnt_r     <= db_cnt_next_s;
            db_level_r   <= db_level_next_s;
            db_level_d_r <= db_level_r;
        end
    end

    assign step_evt_s = db_level_r & ~db_level_d_r;
    assign tick_s     = (state_r == ST_RUN) && (presc_r == PRESC_LAST);

    // Next-state and enable decode; halt outranks every other request
    always_comb begin
        state_next_s  = state_r;
        cpu_ce_next_s = 1'b0;
        if (halt_sync_r) begin
            state_next_s  = ST_HALTED;
            cpu_ce_next_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (run_sync_r) begin
                        state_next_s = ST_RUN;
                    end else if (step_evt_s) begin
                        state_next_s = ST_STEP;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!run_sync_r) begin
                        state_next_s  = ST_IDLE;
                        cpu_ce_next_s = 1'b0;
                    end else begin
                        state_next_s  = ST_RUN;
                        cpu_ce_next_s = tick_s;
                    end
                end
                ST_STEP: begin
                    state_next_s  = ST_IDLE;
                    cpu_ce_next_s = 1'b1;
                end
                ST_HALTED: begin
                    if (clr_sync_r) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_HALTED;
                    end
                end
                default: begin
                    state_next_s  = ST_IDLE;
                    cpu_ce_next_s = 1'b0;
                end
            endcase
        end
    end

    // Prescaler only advances while staying in RUN, so re-entry always starts from zero
    always_comb begin
        presc_next_s = {WIDTH{1'b0}};
        if ((state_r == ST_RUN) && (state_next_s == ST_RUN)) begin
            if (tick_s) begin
                presc_next_s = {WIDTH{1'b0}};
            end else begin
                presc_next_s = presc_r + {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            presc_next_s = {WIDTH{1'b0}};
        end
    end

    // FSM, prescaler and enable registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            presc_r  <= {WIDTH{1'b0}};
            cpu_ce_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            presc_r  <= presc_next_s;
            cpu_ce_r <= cpu_ce_next_s;
        end
    end

    // Pulse counter and heartbeat update on the same edge that raises cpu_ce
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_r <= 16'h0000;
            tick_led_r  <= 1'b0;
        end else if (cpu_ce_next_s) begin
            cycle_cnt_r <= cycle_cnt_r + 16'h0001;
            tick_led_r  <= ~tick_led_r;
        end
    end

    assign cpu_ce    = cpu_ce_r;
    assign state     = state_r;
    assign cycle_cnt = cycle_cnt_r;
    assign tick_led  = tick_led_r;

endmodule
